// File: rtl/if_fetch_pkg.sv
// Shared types and AXI constants for the instruction-fetch controller.
package if_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INST       = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0]  AXI_LEN_SINGLE = 8'd0;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// AXI read-address and read-data channels between the fetch controller and
// the interconnect.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one single-beat AXI read per fetch, stalls the
// IF stage until the word returns, holds it while the pipeline is frozen, and
// drops responses made stale by a redirect.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no read outstanding; launch on fetch_req unless redirecting
// ADDR     | arvalid held with addr_q until arready
// DATA     | waiting for the read beat; kept beat bypasses to inst_out
// DRAIN    | read is stale; accept and discard its beat
// HOLD     | returned word held on inst_out while pipe_stall is high
module if_fetch_ctrl
  import if_fetch_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              redirect,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              fetch_stall,
  output logic              fetch_err,
  if_fetch_ctrl_if.master   axi
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INST);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] inst_q;
  logic              drop_q;

  logic              launch;
  logic              capture;
  logic              rready_c;
  logic              beat_err;
  logic [DATA_W-1:0] beat_word;
  logic              unused_r;

  // rlast is implied by the single-beat burst; rresp[0] does not affect error
  assign unused_r = ^{axi.rlast, axi.rresp[0]};

  assign beat_err  = resp_is_err(axi.rresp);
  assign beat_word = beat_err ? NOP_W : axi.rdata;
  assign launch    = (state_q == ST_IDLE) && fetch_req && !redirect;

  assign axi.araddr  = addr_q;
  assign axi.arvalid = (state_q == ST_ADDR);
  assign axi.arid    = ARID_VAL;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_c;

  assign fetch_stall = fetch_req & ~inst_valid;

  // Next-state and combinational outputs
  always_comb begin
    state_d    = state_q;
    rready_c   = 1'b0;
    inst_valid = 1'b0;
    inst_out   = inst_q;
    fetch_err  = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (axi.arready) state_d = (drop_q || redirect) ? ST_DRAIN : ST_DATA;
      end
      ST_DATA: begin
        rready_c = 1'b1;
        if (axi.rvalid) begin
          if (drop_q || redirect) begin
            state_d = ST_IDLE;
          end else begin
            inst_valid = 1'b1;
            inst_out   = beat_word;
            fetch_err  = beat_err;
            capture    = 1'b1;
            state_d    = pipe_stall ? ST_HOLD : ST_IDLE;
          end
        end else if (redirect) begin
          // beat still owed by the interconnect; swallow it in DRAIN
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rready_c = 1'b1;
        if (axi.rvalid) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_IDLE;
        end else begin
          inst_valid = 1'b1;
          if (!pipe_stall) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Fetch address latched at launch, held stable through ADDR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        addr_q <= '0;
    else if (launch) addr_q <= pc;
  end

  // Returned instruction kept for HOLD cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         inst_q <= NOP_W;
    else if (capture) inst_q <= beat_word;
  end

  // Stale-response flag for a redirect seen while the read is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_q <= 1'b0;
    else if (state_d == ST_IDLE)
      drop_q <= 1'b0;
    else if (redirect && (state_q == ST_ADDR || state_q == ST_DATA))
      drop_q <= 1'b1;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a fetch-level model.
module tb_if_fetch_ctrl;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, redirect, pipe_stall;
  logic [31:0] inst_out;
  logic        inst_valid, fetch_stall, fetch_err;

  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .ARID_VAL(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .redirect   (redirect),
    .pipe_stall (pipe_stall),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .fetch_stall(fetch_stall),
    .fetch_err  (fetch_err),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fetch-level model: a request waiting for AR acceptance, a read waiting
  // for its data, whether that read was invalidated, and a held word
  logic        m_req, m_wait, m_stale, m_hold;
  logic [31:0] m_addr, m_word;

  // DUT outputs sampled at the falling edge
  logic        s_arvalid, s_rready, s_valid, s_err, s_stall;
  logic [31:0] s_araddr, s_inst;
  logic [16:0] s_arfix;

  typedef struct {
    logic [31:0] pc;
    int          ar_wait;
    int          r_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          stall_cyc;
    logic [31:0] exp_inst;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_wait = 0; m_stale = 0; m_hold = 0;
    m_addr = 32'h0; m_word = NOP_INST;
  endtask

  task automatic cyc_check();
    logic        keep, e_valid, e_err;
    logic [31:0] word, e_inst;
    @(negedge clk);
    if (!rst) model_reset();
    s_arvalid = axi.arvalid; s_araddr = axi.araddr; s_rready = axi.rready;
    s_valid = inst_valid; s_inst = inst_out; s_err = fetch_err; s_stall = fetch_stall;
    s_arfix = {axi.arid, axi.arlen, axi.arsize, axi.arburst};
    word    = axi.rresp[1] ? NOP_INST : axi.rdata;
    keep    = m_wait && axi.rvalid && !m_stale && !redirect;
    e_valid = 1'b0; e_err = 1'b0; e_inst = m_word;
    if (keep) begin
      e_valid = 1'b1; e_inst = word; e_err = axi.rresp[1];
    end else if (m_hold) begin
      e_valid = !redirect;
    end
    chk("arvalid", {31'd0, s_arvalid}, {31'd0, m_req});
    if (m_req) begin
      chk("araddr", s_araddr, m_addr);
      chk("ar_fields", {15'd0, s_arfix}, {15'd0, 4'd0, 8'd0, 3'b010, 2'b01});
    end
    chk("rready", {31'd0, s_rready}, {31'd0, m_wait});
    chk("inst_valid", {31'd0, s_valid}, {31'd0, e_valid});
    if (e_valid) chk("inst_out", s_inst, e_inst);
    chk("fetch_err", {31'd0, s_err}, {31'd0, e_err});
    chk("fetch_stall", {31'd0, s_stall}, {31'd0, fetch_req & ~e_valid});
    if (axi.rvalid) chk("rvalid_protocol", {31'd0, s_rready}, 32'd1);
  endtask

  task automatic cyc_end();
    logic [31:0] word;
    @(posedge clk);
    word = axi.rresp[1] ? NOP_INST : axi.rdata;
    if (!rst) begin
      model_reset();
    end else if (m_req) begin
      if (redirect) m_stale = 1;
      if (axi.arready) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (axi.rvalid) begin
        if (!m_stale && !redirect) begin m_word = word; m_hold = pipe_stall; end
        m_wait = 0; m_stale = 0;
      end else if (redirect) begin
        m_stale = 1;
      end
    end else if (m_hold) begin
      if (redirect || !pipe_stall) m_hold = 0;
    end else if (fetch_req && !redirect) begin
      m_req = 1; m_addr = pc; m_stale = 0;
    end
    #1;
  endtask

  task automatic step();
    cyc_check();
    cyc_end();
  endtask

  task automatic run_fetch(input vec_t v);
    int  ar_cnt = 0, r_cnt = 0, vcnt = 0, hs = 0, ar_cyc = 0;
    logic acc = 0, beat, hs_now;
    logic [31:0] first_inst = 32'h0;
    fetch_req = 1; pc = v.pc; redirect = 0;
    for (int k = 0; k < 60; k++) begin
      axi.arready = (ar_cnt == v.ar_wait);
      axi.rvalid  = acc && (r_cnt == v.r_wait);
      axi.rdata   = v.rdata; axi.rresp = v.rresp; axi.rlast = 1'b1;
      pipe_stall  = (vcnt < v.stall_cyc);
      cyc_check();
      if (s_valid) begin
        if (vcnt == 0) begin
          chk("latency", s_valid ? k : -1, v.exp_lat);
          chk("first_inst", s_inst, v.exp_inst);
          chk("first_err", {31'd0, s_err}, {31'd0, v.exp_err});
          first_inst = s_inst;
        end else begin
          chk("hold_inst", s_inst, first_inst);
          chk("hold_err", {31'd0, s_err}, 32'd0);
        end
        vcnt++;
      end else begin
        chk("stall_before_inst", {31'd0, s_stall}, 32'd1);
      end
      hs_now = s_arvalid && axi.arready;
      if (s_arvalid) ar_cyc++;
      if (hs_now) hs++;
      beat = acc && axi.rvalid && s_rready;
      cyc_end();
      if (beat) acc = 0;
      else if (acc) r_cnt++;
      if (hs_now) acc = 1;
      else if (s_arvalid) ar_cnt++;
      if (vcnt == v.stall_cyc + 1) break;
    end
    chk("valid_cycles", vcnt, v.stall_cyc + 1);
    chk("ar_handshakes", hs, 1);
    chk("arvalid_cycles", ar_cyc, v.ar_wait + 1);
    fetch_req = 0; pipe_stall = 0; axi.arready = 0; axi.rvalid = 0;
    cyc_check();
    chk("idle_after_fetch", {31'd0, s_valid}, 32'd0);
    cyc_end();
  endtask

  initial begin
    int   r_dly = 0;
    logic r_acc = 0, beat, hs_now;
    vec_t v;

    vecs[0] = '{32'h100, 0, 0, 32'h0050_0093, 2'b00, 0, 32'h0050_0093, 1'b0, 2};
    vecs[1] = '{32'h104, 4, 0, 32'h00a0_0113, 2'b00, 0, 32'h00a0_0113, 1'b0, 6};
    vecs[2] = '{32'h108, 0, 3, 32'h0020_81b3, 2'b00, 0, 32'h0020_81b3, 1'b0, 5};
    vecs[3] = '{32'h10c, 0, 0, 32'h1234_5678, 2'b00, 3, 32'h1234_5678, 1'b0, 2};
    vecs[4] = '{32'h110, 1, 1, 32'hdead_beef, 2'b10, 0, 32'h0000_0013, 1'b1, 4};
    vecs[5] = '{32'h114, 0, 0, 32'hcafe_f00d, 2'b11, 2, 32'h0000_0013, 1'b1, 2};
    vecs[6] = '{32'h118, 0, 2, 32'h0bad_f00d, 2'b01, 0, 32'h0bad_f00d, 1'b0, 4};

    rst = 0; fetch_req = 1; pc = 32'h0; redirect = 0; pipe_stall = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
    model_reset();

    // reset values
    cyc_check();
    chk("rst_arvalid", {31'd0, s_arvalid}, 32'd0);
    chk("rst_araddr", s_araddr, 32'h0);
    chk("rst_rready", {31'd0, s_rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_inst_out", s_inst, 32'h0000_0013);
    chk("rst_fetch_err", {31'd0, s_err}, 32'd0);
    chk("rst_fetch_stall", {31'd0, s_stall}, 32'd1);
    cyc_end();
    fetch_req = 0;
    cyc_check();
    chk("rst_stall_follows_req", {31'd0, s_stall}, 32'd0);
    cyc_end();
    rst = 1;
    step();

    for (int i = 0; i < 7; i++) run_fetch(vecs[i]);

    // redirect while waiting for data: stale beat dropped, new pc fetched
    fetch_req = 1; pc = 32'h300; axi.arready = 1; axi.rvalid = 0; axi.rresp = 0;
    step();
    cyc_check();
    chk("redir_araddr", s_araddr, 32'h300);
    cyc_end();
    redirect = 1; pc = 32'h200;
    cyc_check();
    chk("redir_data_valid", {31'd0, s_valid}, 32'd0);
    cyc_end();
    redirect = 0; axi.rvalid = 1; axi.rdata = 32'hdead_beef;
    cyc_check();
    chk("drain_valid", {31'd0, s_valid}, 32'd0);
    chk("drain_rready", {31'd0, s_rready}, 32'd1);
    chk("drain_err", {31'd0, s_err}, 32'd0);
    cyc_end();
    axi.rvalid = 0;
    cyc_check();
    chk("after_drain_valid", {31'd0, s_valid}, 32'd0);
    cyc_end();
    cyc_check();
    chk("refetch_arvalid", {31'd0, s_arvalid}, 32'd1);
    chk("refetch_araddr", s_araddr, 32'h200);
    cyc_end();
    axi.rvalid = 1; axi.rdata = 32'h0010_0073;
    cyc_check();
    chk("refetch_valid", {31'd0, s_valid}, 32'd1);
    chk("refetch_inst", s_inst, 32'h0010_0073);
    cyc_end();
    fetch_req = 0; axi.rvalid = 0; axi.arready = 0;
    step();

    // reset asserted while a read is in the data phase
    fetch_req = 1; pc = 32'h400; axi.arready = 1;
    step(); step(); step();
    rst = 0;
    cyc_check();
    chk("midrst_arvalid", {31'd0, s_arvalid}, 32'd0);
    chk("midrst_araddr", s_araddr, 32'h0);
    chk("midrst_rready", {31'd0, s_rready}, 32'd0);
    chk("midrst_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_inst", s_inst, 32'h0000_0013);
    chk("midrst_stall", {31'd0, s_stall}, 32'd1);
    cyc_end();
    fetch_req = 0; axi.arready = 0;
    step();
    rst = 1;
    step();
    v = '{32'h500, 0, 1, 32'h0030_0193, 2'b00, 1, 32'h0030_0193, 1'b0, 3};
    run_fetch(v);

    // randomized traffic with a reactive single-outstanding slave
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 249) != 0);
      fetch_req  = ($urandom_range(0, 9) < 8);
      pc         = 32'h1000 + ($urandom_range(0, 255) << 2);
      redirect   = ($urandom_range(0, 9) == 0);
      pipe_stall = ($urandom_range(0, 9) < 4);
      if (!rst) r_acc = 0;
      axi.arready = $urandom_range(0, 1);
      axi.rvalid  = r_acc && (r_dly == 0);
      axi.rdata   = $urandom;
      axi.rresp   = 2'($urandom_range(0, 3));
      axi.rlast   = 1'b1;
      cyc_check();
      hs_now = s_arvalid && axi.arready;
      beat   = r_acc && axi.rvalid && s_rready;
      cyc_end();
      if (beat) r_acc = 0;
      else if (r_acc && r_dly > 0) r_dly--;
      if (hs_now && rst) begin r_acc = 1; r_dly = $urandom_range(0, 3); end
    end

    rst = 1; fetch_req = 0; redirect = 0; axi.rvalid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
